// File: rtl/cic3_pkg.sv
// cic3_pkg: shared constants and types for the third-order CIC decimator.
// The filter is fixed: order 3, decimation 16, differential delay 1,
// 14-bit two's-complement datapath. Every accumulator wraps modulo 2^14.
// The DC gain is 16^3 = 4096, so outputs stay within -4096..+4096.
package cic3_pkg;
  localparam int CIC_ORDER      = 3;
  localparam int CIC_DECIM      = 16;
  localparam int CIC_DIFF_DELAY = 1;
  localparam int CIC_WIDTH      = 14;
  localparam int CIC_CNT_W      = $clog2(CIC_DECIM);

  typedef logic signed [CIC_WIDTH-1:0] cic_word_t;
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one CIC differentiator running at the decimated rate.
//   clk      : modulator clock
//   reset_n  : async active-low reset, clears the delay register
//   i_en     : decimation strobe; the delay register loads only when it is high
//   i_x      : stage input, taken from the previous stage
//   o_y      : i_x - (i_x captured on the previous strobe); combinational
module cic_comb_stage
  import cic3_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_en,
  input  cic_word_t i_x,
  output cic_word_t o_y
);

  cic_word_t r_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_d <= '0;
    else if (i_en) r_d <= i_x;
  end

  assign o_y = i_x - r_d;

endmodule

// File: rtl/cic3_echip_65.sv
// cic3_echip_65: third-order CIC decimator (R=16, M=1). It converts the 1-bit
// sigma-delta stream into 14-bit signed PCM words.
//   clk      : modulator clock; all state updates on its rising edge
//   reset_n  : async active-low reset, clears every register
//   in       : modulator bit, 1 -> +1, 0 -> -1
//   out      : filtered word, updated once every 16 clocks and held between updates
// Integrators run at the input rate. The comb chain is combinational off i3.
// Its delay registers and the output register load on the cnt==15 edge.
module cic3_echip_65
  import cic3_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  output logic signed [13:0] out
);

  cic_word_t              r_i1, r_i2, r_i3;
  logic [CIC_CNT_W-1:0]   r_cnt;
  cic_word_t              r_out;
  cic_word_t              w_x;
  logic                   w_dump;
  cic_word_t              w_c [CIC_ORDER+1];

  assign w_x    = in ? 14'sd1 : -14'sd1;
  assign w_dump = (r_cnt == CIC_CNT_W'(CIC_DECIM - 1));

  // Each integrator adds the pre-edge value of the stage before it. Wrap is
  // harmless because the comb differences cancel the overflow exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_i3  <= '0;
      r_cnt <= '0;
    end else begin
      r_i1  <= r_i1 + w_x;
      r_i2  <= r_i2 + r_i1;
      r_i3  <= r_i3 + r_i2;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_c[0] = r_i3;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    cic_comb_stage u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_dump),
      .i_x     (w_c[g]),
      .o_y     (w_c[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_out <= '0;
    else if (w_dump) r_out <= w_c[CIC_ORDER];
  end

  assign out = r_out;

endmodule

// File: tb/tb_cic3_echip_65.sv
// tb_cic3_echip_65: scoreboard bench for the CIC decimator. Stimulus pushes
// hand-computed words into a queue. The monitor counts edges since reset
// release, and on every 16th edge it pops one entry and compares it. It also
// confirms that out held still on the 15 edges in between.
module tb_cic3_echip_65;
  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              din = 1'b0;
  logic signed [13:0] dout;

  cic3_echip_65 dut (.clk(clk), .reset_n(reset_n), .in(din), .out(dout));

  always #5 clk = ~clk;

  typedef struct { bit care; int val; int tag; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit care, input int val, input int tag);
    exp_t e;
    e.care = care; e.val = val; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_t%0d: %0d words pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Assert reset at a negedge, check the cleared output, and hold the reset.
  // The caller pushes its expected words and then releases at a negedge.
  task automatic reset_hold(input bit bit0, input int tag);
    @(negedge clk);
    reset_n = 1'b0;
    din     = bit0;
    #1 chk($sformatf("reset_out_t%0d", tag), int'(dout), 0);
    repeat (2) @(negedge clk);
  endtask

  // monitor
  initial begin : mon
    int   ecnt;
    bit   moved;
    logic signed [13:0] prev;
    exp_t e;
    ecnt = 0; moved = 0; prev = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        ecnt = 0; moved = 0; prev = dout;
      end else begin
        ecnt++;
        if (ecnt % 16 == 0) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("cadence_t%0d", e.tag), int'(moved), 0);
            if (e.care) chk($sformatf("word_t%0d", e.tag), int'(dout), e.val);
          end
          prev = dout; moved = 0;
        end else if (dout !== prev) begin
          moved = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // Constant-input settling words and the in=0 -> in=1 step response, with
  // the step landing 5 edges after a word boundary. They are the third
  // difference of 16*j-1 choose 3 and of 16*j-133 choose 3.
  int settle[5] = '{455, 3130, 4095, 4096, 4096};
  int step_w[5] = '{-3766, 764, 4026, 4096, 4096};
  logic [3:0] pats[3] = '{4'b1010, 4'b1000, 4'b1110};
  int         pexp[3] = '{0, -2048, 2048};

  initial begin : stim
    #2 reset_n = 1'b0;
    #1 chk("reset_initial", int'(dout), 0);

    // Scenario 1: in=0 from reset, then the step to in=1 at edge 133.
    reset_hold(1'b0, 100);
    for (int j = 0; j < 5; j++) push(1'b1, -settle[j], 101 + j);
    for (int j = 0; j < 3; j++) push(1'b1, -4096, 106 + j);
    for (int j = 0; j < 5; j++) push(1'b1, step_w[j], 109 + j);
    reset_n = 1'b1;
    repeat (132) @(posedge clk);
    @(negedge clk);
    din = 1'b1;
    drain(1);

    // Scenario 2: periodic patterns. Word 4 onward equals 4096 * mean.
    for (int p = 0; p < 3; p++) begin
      reset_hold(pats[p][3], 200 + p * 10);
      for (int j = 0; j < 3; j++) push(1'b0, 0, 201 + p * 10 + j);
      for (int j = 0; j < 4; j++) push(1'b1, pexp[p], 204 + p * 10 + j);
      reset_n = 1'b1;
      for (int e = 0; e < 112; e++) begin
        din = pats[p][3 - (e % 4)];
        @(posedge clk);
        @(negedge clk);
      end
      drain(2 + p);
    end

    // Scenario 3: settle at +4096, assert reset asynchronously, re-converge.
    reset_hold(1'b1, 300);
    for (int j = 0; j < 5; j++) push(1'b1, settle[j], 301 + j);
    push(1'b1, 4096, 306);
    reset_n = 1'b1;
    drain(5);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("async_clear", int'(dout), 0);
    @(negedge clk);
    for (int j = 0; j < 5; j++) push(1'b1, settle[j], 311 + j);
    @(negedge clk);
    reset_n = 1'b1;
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
